// File: rtl/avmm_host_rd_burst_splitter.sv
// Splits arbitrary Avalon-MM read bursts into 1/2/4-line naturally aligned
// sub-bursts, metered by a pending-line credit limit; read data is returned in order.
module avmm_host_rd_burst_splitter #(
    parameter int ADDR_WIDTH     = 48,
    parameter int DATA_WIDTH     = 512,
    parameter int IN_BURST_WIDTH = 7,
    parameter int MAX_PENDING    = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     s_address,
    input  logic                      s_read,
    input  logic [IN_BURST_WIDTH-1:0] s_burstcount,
    output logic                      s_waitrequest,
    output logic [DATA_WIDTH-1:0]     s_readdata,
    output logic                      s_readdatavalid,
    output logic [ADDR_WIDTH-1:0]     m_address,
    output logic                      m_read,
    output logic [2:0]                m_burstcount,
    input  logic                      m_waitrequest,
    input  logic [DATA_WIDTH-1:0]     m_readdata,
    input  logic                      m_readdatavalid
);
    localparam int LW = ADDR_WIDTH - 6;
    localparam int PW = $clog2(MAX_PENDING + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [LW-1:0]             lad_q, lad_d;
    logic [IN_BURST_WIDTH-1:0] rem_q, rem_d;
    logic [PW-1:0]             pending_q, pending_d;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic                      rvalid_q;
    logic [2:0]                chunk_s;
    logic [PW:0]               credit_sum_s;
    logic                      issue_s;
    logic                      accept_s;
    logic                      addr_lsb_unused_s;

    assign addr_lsb_unused_s = ^s_address[5:0];

    // Largest legal chunk that is aligned to its own size and fits the remainder.
    always_comb begin
        if ((lad_q[1:0] == 2'b00) && (rem_q >= IN_BURST_WIDTH'(4))) begin
            chunk_s = 3'd4;
        end else if ((lad_q[0] == 1'b0) && (rem_q >= IN_BURST_WIDTH'(2))) begin
            chunk_s = 3'd2;
        end else begin
            chunk_s = 3'd1;
        end
    end

    // The credit gate depends only on registered state, so once raised it stays
    // up until accepted: pending can only fall while the chunk is held.
    assign credit_sum_s = {1'b0, pending_q} + (PW+1)'(chunk_s);
    assign issue_s      = (state_q == SPLIT) && (credit_sum_s <= (PW+1)'(MAX_PENDING));
    assign accept_s     = issue_s && !m_waitrequest;

    // Command capture and sub-burst sequencing.
    always_comb begin
        state_d = state_q;
        lad_d   = lad_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (s_read) begin
                    lad_d   = s_address[ADDR_WIDTH-1:6];
                    rem_d   = s_burstcount;
                    state_d = (s_burstcount != {IN_BURST_WIDTH{1'b0}}) ? SPLIT : IDLE;
                end else begin
                    state_d = IDLE;
                end
            end
            SPLIT: begin
                if (accept_s) begin
                    lad_d   = lad_q + LW'(chunk_s);
                    rem_d   = rem_q - IN_BURST_WIDTH'(chunk_s);
                    state_d = (rem_q == IN_BURST_WIDTH'(chunk_s)) ? IDLE : SPLIT;
                end else begin
                    state_d = SPLIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Returns arriving with nothing outstanding (e.g. after a reset) are ignored.
    always_comb begin
        pending_d = pending_q;
        if (accept_s) begin
            pending_d = pending_q + PW'(chunk_s);
        end else begin
            pending_d = pending_q;
        end
        if (m_readdatavalid && (pending_d != {PW{1'b0}})) begin
            pending_d = pending_d - PW'(1);
        end else begin
            pending_d = pending_d;
        end
    end

    // State, credit and read-data pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            lad_q     <= {LW{1'b0}};
            rem_q     <= {IN_BURST_WIDTH{1'b0}};
            pending_q <= {PW{1'b0}};
            rdata_q   <= {DATA_WIDTH{1'b0}};
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lad_q     <= lad_d;
            rem_q     <= rem_d;
            pending_q <= pending_d;
            rdata_q   <= m_readdata;
            rvalid_q  <= m_readdatavalid;
        end
    end

    assign s_waitrequest   = reset | (state_q == SPLIT);
    assign s_readdata      = rdata_q;
    assign s_readdatavalid = rvalid_q;
    assign m_read          = issue_s;
    assign m_address       = {lad_q, 6'b000000};
    assign m_burstcount    = chunk_s;

endmodule

// File: tb/tb_avmm_host_rd_burst_splitter.sv
// Bench for avmm_host_rd_burst_splitter: queue-based model of the split rule and
// credit limit checked every cycle, plus directed literal expectations.
module tb_avmm_host_rd_burst_splitter;
    localparam int MAXP = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic [47:0]  s_address;
    logic         s_read;
    logic [6:0]   s_burstcount;
    logic         s_waitrequest;
    logic [511:0] s_readdata;
    logic         s_readdatavalid;
    logic [47:0]  m_address;
    logic         m_read;
    logic [2:0]   m_burstcount;
    logic         m_waitrequest;
    logic [511:0] m_readdata = '0;
    logic         m_readdatavalid = 1'b0;

    logic [47:0]  s4_address;
    logic         s4_read;
    logic [6:0]   s4_burstcount;
    logic         s4_waitrequest;
    logic [511:0] s4_readdata;
    logic         s4_readdatavalid;
    logic [47:0]  m4_address;
    logic         m4_read;
    logic [2:0]   m4_burstcount;
    logic         m4_waitrequest;
    logic [511:0] m4_readdata;
    logic         m4_readdatavalid;

    typedef struct {
        logic [47:0] addr;
        int          len;
        int          cyc;
    } sb_t;

    sb_t          exp_q[$];
    sb_t          log_q[$];
    int           mpend = 0;
    int           owed = 0;
    logic         prev_v = 1'b0;
    logic [511:0] prev_d = '0;
    int           cyc = 0;
    int           rv_count = 0;
    logic         ret_en = 1'b1;
    logic [31:0]  data_cnt = 32'd0;
    int           nchecks = 0;
    int           nerrs = 0;

    avmm_host_rd_burst_splitter u_dut (
        .clk(clk), .reset(rst),
        .s_address(s_address), .s_read(s_read), .s_burstcount(s_burstcount),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .m_address(m_address), .m_read(m_read), .m_burstcount(m_burstcount),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid)
    );

    avmm_host_rd_burst_splitter #(.MAX_PENDING(4)) u_dut4 (
        .clk(clk), .reset(rst),
        .s_address(s4_address), .s_read(s4_read), .s_burstcount(s4_burstcount),
        .s_waitrequest(s4_waitrequest), .s_readdata(s4_readdata), .s_readdatavalid(s4_readdatavalid),
        .m_address(m4_address), .m_read(m4_read), .m_burstcount(m4_burstcount),
        .m_waitrequest(m4_waitrequest), .m_readdata(m4_readdata), .m_readdatavalid(m4_readdatavalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Expected sub-bursts: largest of 4/2/1 lines that divides the line address and fits.
    task automatic push_cmd(input logic [47:0] a, input int n);
        logic [41:0] l;
        int          r;
        int          c;
        l = a[47:6];
        r = n;
        while (r > 0) begin
            if ((l % 4 == 0) && (r >= 4)) c = 4;
            else if ((l % 2 == 0) && (r >= 2)) c = 2;
            else c = 1;
            exp_q.push_back('{addr: {l, 6'b000000}, len: c, cyc: 0});
            l = l + 42'(c);
            r -= c;
        end
    endtask

    task automatic monitor();
        logic        stall_prev;
        logic [47:0] pa;
        logic [2:0]  pb;
        logic        acc;
        logic        ret;
        logic        exp_rd;
        stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                exp_q.delete();
                mpend = 0;
                owed = 0;
                prev_v = 1'b0;
                stall_prev = 1'b0;
                m_readdatavalid = 1'b0;
            end else begin
                chk("s_waitrequest", s_waitrequest, exp_q.size() != 0);
                exp_rd = 1'b0;
                if (exp_q.size() != 0) exp_rd = (mpend + exp_q[0].len <= MAXP);
                chk("m_read", m_read, exp_rd);
                if (m_read && exp_q.size() != 0) begin
                    chk("m_address", m_address, exp_q[0].addr);
                    chk("m_burstcount", m_burstcount, exp_q[0].len);
                end
                if (stall_prev) begin
                    chk("hold_m_read", m_read, 1'b1);
                    chk("hold_m_address", m_address, pa);
                    chk("hold_m_burstcount", m_burstcount, pb);
                end
                chk("s_readdatavalid", s_readdatavalid, prev_v);
                if (prev_v) chk("s_readdata", s_readdata, prev_d);
                if (s_readdatavalid) rv_count++;

                acc = m_read && !m_waitrequest;
                ret = ret_en && (owed > 0);
                m_readdatavalid = ret;
                if (ret) begin
                    data_cnt = data_cnt + 32'd1;
                    m_readdata = {16{data_cnt}};
                    owed--;
                    mpend--;
                end
                prev_v = ret;
                prev_d = m_readdata;
                if (acc && exp_q.size() != 0) begin
                    log_q.push_back('{addr: m_address, len: int'(m_burstcount), cyc: cyc});
                    mpend += exp_q[0].len;
                    owed += exp_q[0].len;
                    void'(exp_q.pop_front());
                end
                if (s_read && !s_waitrequest && s_burstcount != 7'd0) push_cmd(s_address, int'(s_burstcount));
                stall_prev = m_read && m_waitrequest;
                pa = m_address;
                pb = m_burstcount;
            end
        end
    endtask

    task automatic issue(input logic [47:0] a, input logic [6:0] bc);
        int n;
        n = 0;
        @(posedge clk); #1;
        s_address = a;
        s_burstcount = bc;
        s_read = 1'b1;
        @(negedge clk);
        while (s_waitrequest && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("issue_timeout", 1'b1, 1'b0);
        @(posedge clk); #1;
        s_read = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        @(negedge clk);
        while (s_waitrequest && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (n >= 500) chk("idle_timeout", 1'b1, 1'b0);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (owed > 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) chk("drain_timeout", 1'b1, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_log(input int idx, input logic [47:0] a, input int len);
        if (idx < log_q.size()) begin
            chk("log_addr", log_q[idx].addr, a);
            chk("log_len", log_q[idx].len, len);
        end else begin
            chk("log_missing", log_q.size(), idx + 1);
        end
    endtask

    initial begin
        int base;
        int n;
        int rv0;
        rst = 1'b1;
        s_address = '0; s_read = 1'b0; s_burstcount = '0; m_waitrequest = 1'b0;
        s4_address = '0; s4_read = 1'b0; s4_burstcount = '0; m4_waitrequest = 1'b0;
        m4_readdata = '0; m4_readdatavalid = 1'b0;
        fork
            monitor();
        join_none

        @(posedge clk); #1;
        chk("rst_s_waitrequest", s_waitrequest, 1'b1);
        chk("rst_m_read", m_read, 1'b0);
        chk("rst_m_address", m_address, 48'h0);
        chk("rst_m_burstcount", m_burstcount, 3'd1);
        chk("rst_s_readdatavalid", s_readdatavalid, 1'b0);
        chk("rst_s_readdata", s_readdata, 512'h0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_s_waitrequest", s_waitrequest, 1'b0);

        // Burst 8 at 0: two 4-line sub-bursts on consecutive cycles
        base = log_q.size(); rv0 = rv_count;
        issue(48'h0, 7'd8);
        wait_idle(n);
        wait_drain();
        chk("b8_count", log_q.size() - base, 2);
        chk_log(base, 48'h000, 4);
        chk_log(base + 1, 48'h100, 4);
        if (log_q.size() >= base + 2) chk("b8_consecutive", log_q[base+1].cyc - log_q[base].cyc, 1);
        chk("b8_beats", rv_count - rv0, 8);

        // Burst 7 at line 1
        base = log_q.size();
        issue(48'h40, 7'd7);
        wait_idle(n);
        wait_drain();
        chk("b7_count", log_q.size() - base, 3);
        chk_log(base, 48'h040, 1);
        chk_log(base + 1, 48'h080, 2);
        chk_log(base + 2, 48'h100, 4);

        // Burst 3 at line 3: exactly two busy cycles
        base = log_q.size();
        issue(48'hC0, 7'd3);
        wait_idle(n);
        chk("b3_wait_cycles", n, 2);
        wait_drain();
        chk_log(base, 48'h0C0, 1);
        chk_log(base + 1, 48'h100, 2);

        // Stall held on (0x080, 2)
        base = log_q.size();
        m_waitrequest = 1'b1;
        issue(48'h80, 7'd2);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("stall_m_read", m_read, 1'b1);
        chk("stall_no_accept", log_q.size() - base, 0);
        @(posedge clk); #1;
        m_waitrequest = 1'b0;
        wait_idle(n);
        wait_drain();
        chk("stall_single_accept", log_q.size() - base, 1);
        chk_log(base, 48'h080, 2);

        // Line address wraps at the top of the address space
        base = log_q.size();
        issue(48'hFFFF_FFFF_FF80, 7'd4);
        wait_idle(n);
        wait_drain();
        chk_log(base, 48'hFFFF_FFFF_FF80, 2);
        chk_log(base + 1, 48'h0, 2);

        // Zero-length burst is consumed silently
        base = log_q.size(); rv0 = rv_count;
        issue(48'h200, 7'd0);
        @(negedge clk);
        chk("b0_s_waitrequest", s_waitrequest, 1'b0);
        repeat (4) @(negedge clk);
        chk("b0_no_subburst", log_q.size() - base, 0);
        chk("b0_no_data", rv_count - rv0, 0);

        // Credit limit of 4 on the second instance
        @(posedge clk); #1;
        s4_address = 48'h0; s4_burstcount = 7'd8; s4_read = 1'b1;
        @(negedge clk);
        chk("c4_s_waitrequest", s4_waitrequest, 1'b0);
        @(posedge clk); #1;
        s4_read = 1'b0;
        @(negedge clk);
        chk("c4_first_read", m4_read, 1'b1);
        chk("c4_first_addr", m4_address, 48'h0);
        chk("c4_first_bc", m4_burstcount, 3'd4);
        repeat (3) begin
            @(negedge clk);
            chk("c4_blocked", m4_read, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            m4_readdatavalid = 1'b1;
            m4_readdata = 512'(i + 1);
            @(negedge clk);
            chk("c4_partial_return", m4_read, 1'b0);
        end
        @(posedge clk); #1;
        m4_readdata = 512'd4;
        @(negedge clk);
        chk("c4_three_back_read", m4_read, 1'b0);
        chk("c4_rdv3", s4_readdatavalid, 1'b1);
        chk("c4_rdata3", s4_readdata, 512'd3);
        @(posedge clk); #1;
        m4_readdatavalid = 1'b0;
        @(negedge clk);
        chk("c4_second_read", m4_read, 1'b1);
        chk("c4_second_addr", m4_address, 48'h100);
        chk("c4_second_bc", m4_burstcount, 3'd4);
        chk("c4_rdata4", s4_readdata, 512'd4);

        // Asynchronous reset mid-split with data still flowing
        @(posedge clk); #1;
        ret_en = 1'b0;
        issue(48'h400, 7'd4);
        wait_idle(n);
        m_waitrequest = 1'b1;
        issue(48'h0, 7'd8);
        @(posedge clk); #1;
        ret_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_reset_m_read", m_read, 1'b1);
        chk("pre_reset_rdv", s_readdatavalid, 1'b1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_m_read", m_read, 1'b0);
        chk("async_s_readdatavalid", s_readdatavalid, 1'b0);
        chk("async_s_waitrequest", s_waitrequest, 1'b1);
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        m_waitrequest = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", s_waitrequest, 1'b0);
        base = log_q.size();
        issue(48'h1000, 7'd1);
        wait_idle(n);
        wait_drain();
        chk("post_reset_count", log_q.size() - base, 1);
        chk_log(base, 48'h1000, 1);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
